// File: rtl/seg7_scan_n.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_n
// Description : N-digit time-multiplexed 7-segment scanner for common-anode
//               displays (seg/an/dp active-low). Frame-latched inputs,
//               per-digit decimal point and blanking, 16-level PWM brightness,
//               one-cycle anode ghost guard at slot ends, frame-start strobe.
//               Optional leading-zero suppression: SEG7_SCAN_N_LZ_SUPPRESS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_n #(
   parameter int NUM_DIGITS = 8,
   parameter int TICK_DIV   = 100000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [4*NUM_DIGITS-1:0]   digits,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic [NUM_DIGITS-1:0]     blank,
   input  logic [3:0]                brightness,
   output logic [6:0]                seg,
   output logic                      dp,
   output logic [NUM_DIGITS-1:0]     an,
   output logic                      frame_tick
);

   localparam int PW = (TICK_DIV / 16 > 1) ? $clog2(TICK_DIV / 16) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] c_PRE_MAX = PW'(TICK_DIV / 16 - 1);
   localparam logic [IW-1:0] c_IDX_MAX = IW'(NUM_DIGITS - 1);

   // Scan counters
   logic [PW-1:0] r_pre;
   logic [3:0]    r_phase;
   logic [IW-1:0] r_idx;

   // Frame shadow registers
   logic [4*NUM_DIGITS-1:0] r_sh_dig;
   logic [NUM_DIGITS-1:0]   r_sh_dp;
   logic [NUM_DIGITS-1:0]   r_sh_blank;
   logic [3:0]              r_sh_br;

   // Registered outputs
   logic [NUM_DIGITS-1:0] r_an;
   logic [6:0]            r_seg;
   logic                  r_dp;
   logic                  r_ft;

   logic                    w_pre_wrap;
   logic                    w_slot_end;
   logic                    w_latch;
   logic [4*NUM_DIGITS-1:0] w_src_dig;
   logic [NUM_DIGITS-1:0]   w_src_dp;
   logic [NUM_DIGITS-1:0]   w_src_blank;
   logic [3:0]              w_src_br;
   logic [NUM_DIGITS-1:0]   w_sup;
   logic [3:0]              w_nib;
   logic                    w_dp_req;
   logic                    w_blk;
   logic                    w_on;
   logic [6:0]              w_dec;

   assign w_pre_wrap = (r_pre == c_PRE_MAX);
   assign w_slot_end = w_pre_wrap && (r_phase == 4'hF);
   // Counters at all-zero mark the first cycle of a frame (also right after reset)
   assign w_latch    = (r_pre == '0) && (r_phase == 4'h0) && (r_idx == '0);

   // On the latch cycle the shadow is being loaded, so bypass it with live inputs
   assign w_src_dig   = w_latch ? digits     : r_sh_dig;
   assign w_src_dp    = w_latch ? dp_in      : r_sh_dp;
   assign w_src_blank = w_latch ? blank      : r_sh_blank;
   assign w_src_br    = w_latch ? brightness : r_sh_br;

   // Prescaler, PWM phase and digit index
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pre   <= '0;
         r_phase <= 4'h0;
         r_idx   <= '0;
      end else begin
         r_pre <= w_pre_wrap ? '0 : r_pre + 1'b1;
         if (w_pre_wrap) begin
            r_phase <= r_phase + 4'h1;
         end
         if (w_slot_end) begin
            r_idx <= (r_idx == c_IDX_MAX) ? '0 : r_idx + 1'b1;
         end
      end
   end

   // Capture display inputs once per frame so a frame never tears
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sh_dig   <= '0;
         r_sh_dp    <= '0;
         r_sh_blank <= '0;
         r_sh_br    <= 4'h0;
      end else if (w_latch) begin
         r_sh_dig   <= digits;
         r_sh_dp    <= dp_in;
         r_sh_blank <= blank;
         r_sh_br    <= brightness;
      end
   end

`ifdef SEG7_SCAN_N_LZ_SUPPRESS_EN
   // Leading-zero mask from frame-latched values: zero run from the top, no dp
   always_comb begin : p_lz
      logic l_run;
      w_sup = '0;
      l_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         l_run    = l_run && (w_src_dig[4*i +: 4] == 4'h0) && !w_src_dp[i];
         w_sup[i] = l_run;
      end
   end
`else
   assign w_sup = '0;
`endif

   // Select the active digit's nibble and flags
   always_comb begin
      w_nib    = 4'h0;
      w_dp_req = 1'b0;
      w_blk    = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_idx == IW'(i)) begin
            w_nib    = w_src_dig[4*i +: 4];
            w_dp_req = w_src_dp[i];
            w_blk    = w_src_blank[i] | w_sup[i];
         end
      end
   end

   // Hex to active-low gfedcba
   always_comb begin
      case (w_nib)
         4'h0: w_dec = 7'h40;
         4'h1: w_dec = 7'h79;
         4'h2: w_dec = 7'h24;
         4'h3: w_dec = 7'h30;
         4'h4: w_dec = 7'h19;
         4'h5: w_dec = 7'h12;
         4'h6: w_dec = 7'h02;
         4'h7: w_dec = 7'h78;
         4'h8: w_dec = 7'h00;
         4'h9: w_dec = 7'h10;
         4'hA: w_dec = 7'h08;
         4'hB: w_dec = 7'h03;
         4'hC: w_dec = 7'h46;
         4'hD: w_dec = 7'h21;
         4'hE: w_dec = 7'h06;
         default: w_dec = 7'h0E;
      endcase
   end

   // Anode on within the PWM window; last cycle of a slot is the ghost guard
   assign w_on = (r_phase <= w_src_br) && !w_slot_end;

   // Register all display outputs one cycle behind the counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_an  <= '1;
         r_seg <= 7'h7F;
         r_dp  <= 1'b1;
         r_ft  <= 1'b0;
      end else begin
         r_an <= '1;
         if (w_on) begin
            r_an[r_idx] <= 1'b0;
         end
         r_seg <= w_blk ? 7'h7F : w_dec;
         r_dp  <= w_blk ? 1'b1  : ~w_dp_req;
         r_ft  <= w_latch;
      end
   end

   assign an         = r_an;
   assign seg        = r_seg;
   assign dp         = r_dp;
   assign frame_tick = r_ft;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_n
// Description : Self-checking bench for seg7_scan_n (4 digits, 32-cycle slots)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_n;

   localparam int N     = 4;
   localparam int TD    = 32;
   localparam int FRAME = N * TD;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [4*N-1:0] digits = 16'hA1C3;
   logic [N-1:0]  dp_in = 4'b0100;
   logic [N-1:0]  blank = 4'b0000;
   logic [3:0]    brightness = 4'hF;
   logic [6:0]    seg;
   logic          dp;
   logic [N-1:0]  an;
   logic          frame_tick;

   int n_cmp = 0;
   int n_err = 0;

   seg7_scan_n #(.NUM_DIGITS(N), .TICK_DIV(TD)) dut (
      .clk(clk), .rst(rst), .digits(digits), .dp_in(dp_in), .blank(blank),
      .brightness(brightness), .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   logic [6:0] c_hex [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int             k = 0;
   bit             model_ok = 0;
   logic [4*N-1:0] m_dig;
   logic [N-1:0]   m_dp, m_blank;
   logic [3:0]     m_br;
   logic [N-1:0]   e_an;
   logic [6:0]     e_seg;
   logic           e_dp, e_ft;

   always @(posedge clk) begin
      int s, pos, ph, nib;
      bit blk;
      model_ok = 1;
      if (rst) begin
         k = 0; e_an = '1; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0;
      end else begin
         if (k % FRAME == 0) begin
            m_dig = digits; m_dp = dp_in; m_blank = blank; m_br = brightness;
         end
         s   = (k / TD) % N;
         pos = k % TD;
         ph  = pos / (TD / 16);
         e_an = '1;
         if (ph <= int'(m_br) && pos != TD - 1) e_an[s] = 1'b0;
         nib = int'((m_dig >> (4 * s)) & 16'hF);
         blk = m_blank[s];
`ifdef SEG7_SCAN_N_LZ_SUPPRESS_EN
         if (s != 0) begin
            bit z;
            z = 1;
            for (int j = s; j < N; j++)
               if (((m_dig >> (4 * j)) & 16'hF) != 0 || m_dp[j]) z = 0;
            if (z) blk = 1;
         end
`endif
         e_seg = blk ? 7'h7F : c_hex[nib];
         e_dp  = blk ? 1'b1 : ~m_dp[s];
         e_ft  = (k % FRAME == 0);
         k++;
      end
   end

   // Compare every cycle, away from the active edge
   always @(negedge clk) begin
      if (model_ok) begin
         check("an", int'(an), int'(e_an));
         check("seg", int'(seg), int'(e_seg));
         check("dp", int'(dp), int'(e_dp));
         check("frame_tick", int'(frame_tick), int'(e_ft));
      end
   end

   // ---------------- directed helpers ----------------
   task automatic wait_an(input logic [N-1:0] v);
      int t = 0;
      do begin @(negedge clk); t++; end while (an !== v && t < 400);
      check("wait_an_timeout", int'(an), int'(v));
   endtask

   task automatic wait_ft();
      int t = 0;
      do begin @(negedge clk); t++; end while (frame_tick !== 1'b1 && t < 400);
      check("wait_ft_timeout", int'(frame_tick), 1);
   endtask

   task automatic count_low(input int bitn, output int cnt);
      cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
         if (an[bitn] == 1'b0) cnt++;
         @(negedge clk);
      end
   endtask

   initial begin
      int cnt, per;
      repeat (3) @(negedge clk);
      check("rst_an", int'(an), 4'hF);
      check("rst_seg", int'(seg), 7'h7F);
      check("rst_dp", int'(dp), 1);
      check("rst_ft", int'(frame_tick), 0);
      rst = 1'b0;

      // Decode and scan order: A1C3 with dp on digit 2
      @(negedge clk);
      check("first_ft", int'(frame_tick), 1);
      check("first_an", int'(an), 4'b1110);
      check("dec_d0", int'(seg), 7'h30);
      wait_an(4'b1101); check("dec_d1", int'(seg), 7'h46);
      wait_an(4'b1011); check("dec_d2", int'(seg), 7'h79); check("dp_d2", int'(dp), 0);
      wait_an(4'b0111); check("dec_d3", int'(seg), 7'h08); check("dp_d3", int'(dp), 1);

      // Frame period
      wait_ft();
      per = 0;
      do begin @(negedge clk); per++; end while (frame_tick !== 1'b1 && per < 400);
      check("frame_period", per, 128);

      // Frame latch: mid-frame change stays invisible until next frame
      digits = 16'h1234; dp_in = 4'b0000;
      wait_ft();
      wait_an(4'b1011); check("latch_d2", int'(seg), 7'h24);
      digits = 16'h5678;
      wait_an(4'b0111); check("latch_d3_old", int'(seg), 7'h79);
      wait_an(4'b1110); check("latch_d0_new", int'(seg), 7'h00);
      wait_an(4'b1101); check("latch_d1_new", int'(seg), 7'h78);

      // Brightness
      brightness = 4'h3;
      wait_ft(); count_low(1, cnt); check("bright3_on", cnt, 8);
      brightness = 4'h0;
      wait_ft(); count_low(1, cnt); check("bright0_on", cnt, 2);
      brightness = 4'hF;
      wait_ft(); count_low(1, cnt); check("brightF_on", cnt, 31);

      // Blank digit 1, then reset mid-scan in slot 2
      blank = 4'b0010;
      wait_ft();
      wait_an(4'b1101); check("blank_seg", int'(seg), 7'h7F); check("blank_dp", int'(dp), 1);
      wait_an(4'b1011);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_an", int'(an), 4'hF); check("midrst_seg", int'(seg), 7'h7F);
      rst = 1'b0;
      @(negedge clk);
      check("restart_ft", int'(frame_tick), 1); check("restart_an", int'(an), 4'b1110);
      blank = 4'b0000;

      // Leading zeros
      digits = 16'h0070;
      wait_ft();
      wait_an(4'b1101); check("lz_d1", int'(seg), 7'h78);
      wait_an(4'b0111);
`ifdef SEG7_SCAN_N_LZ_SUPPRESS_EN
      check("lz_d3", int'(seg), 7'h7F);
      digits = 16'h0000;
      wait_ft(); check("lz0_d0", int'(seg), 7'h40);
      wait_an(4'b1101); check("lz0_d1", int'(seg), 7'h7F);
`else
      check("nolz_d3", int'(seg), 7'h40);
`endif
      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
